// File: rtl/ifu_pkg.sv
// Shared constants and helpers for the cirno9 prefetching fetch unit.
package ifu_pkg;

  localparam int unsigned INST_BYTES   = 4;
  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef logic [INST_W-1:0] inst_t;

  // Bits needed to hold a counter that ranges over 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction queue: DEPTH x 32 synchronous FIFO with flush.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  logic  pop_i,
  input  logic  flush_i,
  input  inst_t wdata_i,
  output inst_t rdata_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  inst_t         mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit tells full from empty when the index bits match.
  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Guarded handshakes; flush wins over both.
  always_comb begin
    do_push = push_i && !flush_i && (!full_o || pop_i);
    do_pop  = pop_i && !flush_i && !empty_o;
  end

  // Pointer next state; natural wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ifu_pf.sv
// Prefetching fetch unit: fetch-PC generator, credit-limited memory port,
// instruction queue to decode, and redirect with stale-response dropping.
module ifu_pf
  import ifu_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_req_val,
  input  logic            i_req_rdy,
  output logic [XLEN-1:0] o_req_addr,
  input  logic            i_rsp_val,
  input  logic [31:0]     i_rsp_data,
  output logic            o_in_val,
  input  logic            i_in_rdy,
  output logic [31:0]     o_in,
  output logic [XLEN-1:0] o_pc_r,
  input  logic            i_setpc,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pcadd
);

  localparam int unsigned OCC_W = cnt_width(DEPTH);
  localparam int unsigned OUT_W = cnt_width(MAX_OUT);
  localparam int unsigned CRW   = OCC_W + 1;

  logic [XLEN-1:0]  fpc_q, fpc_d;
  logic [XLEN-1:0]  dpc_q, dpc_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] drop_q, drop_d;
  logic             req_val_q, req_val_d;

  logic             req_hs;
  logic             in_val;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  target;
  logic [CRW-1:0]   credit_sum;
  inst_t            head;
  logic             fifo_full;
  logic             fifo_empty;

  // Handshakes; a response in a redirect cycle or while draining is stale.
  always_comb begin
    req_hs = req_val_q && i_req_rdy;
    in_val = (occ_q != '0) && !i_setpc;
    pop    = in_val && i_in_rdy;
    push   = i_rsp_val && (drop_q == '0) && !i_setpc;
    target = i_pc + i_pcadd;
  end

  // Next-state for PCs and the occupancy / in-flight / drop counters.
  always_comb begin
    fpc_d  = fpc_q;
    dpc_d  = dpc_q;
    occ_d  = occ_q;
    drop_d = drop_q;
    out_d  = out_q;

    if (req_hs && !i_rsp_val)      out_d = out_q + OUT_W'(1);
    else if (!req_hs && i_rsp_val) out_d = out_q - OUT_W'(1);

    if (i_setpc) begin
      fpc_d  = target;
      dpc_d  = target;
      occ_d  = '0;
      drop_d = out_d;
    end else begin
      if (req_hs) fpc_d = fpc_q + XLEN'(INST_BYTES);
      if (pop)    dpc_d = dpc_q + XLEN'(INST_BYTES);
      if (push && !pop)      occ_d = occ_q + OCC_W'(1);
      else if (!push && pop) occ_d = occ_q - OCC_W'(1);
      if (i_rsp_val && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);
    end
  end

  // Request credit: live entries (queued + in flight - stale) must leave a slot.
  always_comb begin
    credit_sum = CRW'(occ_d) + CRW'(out_d) - CRW'(drop_d);
    req_val_d  = (out_d < OUT_W'(MAX_OUT)) && (credit_sum < CRW'(DEPTH));
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q     <= RESET_PC;
      dpc_q     <= RESET_PC;
      occ_q     <= '0;
      out_q     <= '0;
      drop_q    <= '0;
      req_val_q <= 1'b0;
    end else begin
      fpc_q     <= fpc_d;
      dpc_q     <= dpc_d;
      occ_q     <= occ_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      req_val_q <= req_val_d;
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_setpc),
    .wdata_i (i_rsp_data),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output drive.
  always_comb begin
    o_req_val  = req_val_q;
    o_req_addr = fpc_q;
    o_in_val   = in_val;
    o_in       = head;
    o_pc_r     = dpc_q;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));
  a_out_max: assert property (@(posedge clk) disable iff (!rst_n)
    out_q <= OUT_W'(MAX_OUT));
  a_rsp_in_flight: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_rsp_val && (out_q == '0)));
  a_occ_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (occ_q == '0) == fifo_empty);

endmodule

// File: tb/tb_ifu_pf.sv
// Bench for ifu_pf: memory model, decode-side scoreboard, directed phases.
module tb_ifu_pf;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_req_val;
  logic        i_req_rdy;
  logic [31:0] o_req_addr;
  logic        i_rsp_val;
  logic [31:0] i_rsp_data;
  logic        o_in_val;
  logic        i_in_rdy;
  logic [31:0] o_in;
  logic [31:0] o_pc_r;
  logic        i_setpc;
  logic [31:0] i_pc;
  logic [31:0] i_pcadd;

  int errors    = 0;
  int checks    = 0;
  int delivered = 0;
  int mem_lat   = 1;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  ifu_pf #(
    .XLEN     (XLEN),
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_req_val  (o_req_val),
    .i_req_rdy  (i_req_rdy),
    .o_req_addr (o_req_addr),
    .i_rsp_val  (i_rsp_val),
    .i_rsp_data (i_rsp_data),
    .o_in_val   (o_in_val),
    .i_in_rdy   (i_in_rdy),
    .o_in       (o_in),
    .o_pc_r     (o_pc_r),
    .i_setpc    (i_setpc),
    .i_pc       (i_pc),
    .i_pcadd    (i_pcadd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_batch(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 200; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_deliv(input int target, input string name);
    for (int i = 0; i < 30 && delivered < target; i++) tick();
    chk(name, 32'(delivered >= target), 32'd1);
  endtask

  // Memory model: in-order responses mem_lat cycles after each handshake.
  initial begin : memory
    logic        hs;
    logic [31:0] a;
    int          mcyc;
    mcyc       = 0;
    i_rsp_val  = 1'b0;
    i_rsp_data = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && o_req_val && i_req_rdy;
      a  = o_req_addr;
      @(posedge clk);
      #1;
      mcyc++;
      if (!rst_n) begin
        pend.delete();
        i_rsp_val = 1'b0;
      end else begin
        if (hs) pend.push_back('{addr: a, due: mcyc + mem_lat - 1});
        if (pend.size() != 0 && pend[0].due <= mcyc) begin
          i_rsp_val  = 1'b1;
          i_rsp_data = mem_word(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          i_rsp_val = 1'b0;
        end
      end
    end
  end

  // Monitor: every decode handshake pops the scoreboard; bounds checked each cycle.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("occ_bound", 32'(dut.occ_q <= 3'(DEPTH)), 32'd1);
        chk("out_bound", 32'(dut.out_q <= 2'(MAX_OUT)), 32'd1);
        if (o_in_val && i_in_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_unexpected: got pc 0x%08h, required no delivery", o_pc_r);
          end else begin
            e = exp_q.pop_front();
            chk("deliver_pc", o_pc_r, e);
            chk("deliver_inst", o_in, mem_word(e));
            delivered++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin : stim
    int   d0;
    logic found;
    logic rsp_r;
    rst_n     = 1'b0;
    i_req_rdy = 1'b1;
    i_in_rdy  = 1'b1;
    i_setpc   = 1'b0;
    i_pc      = '0;
    i_pcadd   = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_val", 32'(o_req_val), 32'd0);
    chk("rst_in_val", 32'(o_in_val), 32'd0);
    chk("rst_pc_r", o_pc_r, RST_PC);
    chk("rst_req_addr", o_req_addr, RST_PC);
    push_batch(RST_PC);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Streaming at latency 1.
    tick();
    @(negedge clk);
    chk("c0_req_val", 32'(o_req_val), 32'd1);
    chk("c0_req_addr", o_req_addr, RST_PC);
    tick();
    @(negedge clk);
    chk("c1_req_addr", o_req_addr, RST_PC + 32'd4);
    chk("c1_in_val", 32'(o_in_val), 32'd0);
    for (int c = 2; c < 12; c++) begin
      tick();
      @(negedge clk);
      chk("stream_in_val", 32'(o_in_val), 32'd1);
      chk("stream_pc", o_pc_r, RST_PC + 32'(4 * (c - 2)));
    end

    // Decode stall fills exactly DEPTH entries.
    tick();
    i_in_rdy = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("stall_occ", 32'(dut.occ_q), 32'd4);
    chk("stall_out", 32'(dut.out_q), 32'd0);
    chk("stall_req_val", 32'(o_req_val), 32'd0);
    chk("stall_in_val", 32'(o_in_val), 32'd1);
    tick();
    i_in_rdy = 1'b1;

    // Latency 3.
    mem_lat = 3;
    d0 = delivered;
    repeat (30) tick();
    chk("lat3_progress", 32'(delivered - d0 >= 10), 32'd1);

    // Redirect with two requests in flight.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (dut.out_q == 2'd2) found = 1'b1;
    end
    chk("redir_two_in_flight", 32'(found), 32'd1);
    i_pc    = 32'h0000_1000;
    i_pcadd = 32'h0000_0020;
    i_setpc = 1'b1;
    push_batch(32'h0000_1020);
    @(negedge clk);
    chk("redir_in_val_forced", 32'(o_in_val), 32'd0);
    rsp_r = i_rsp_val;
    tick();
    i_setpc = 1'b0;
    @(negedge clk);
    chk("redir_occ", 32'(dut.occ_q), 32'd0);
    chk("redir_req_addr", o_req_addr, 32'h0000_1020);
    chk("redir_drop", 32'(dut.drop_q), rsp_r ? 32'd1 : 32'd2);
    d0 = delivered;
    wait_deliv(d0 + 1, "redir_first_delivery");

    // Redirect coinciding with a handshake and a response; target near wrap.
    mem_lat = 1;
    repeat (10) tick();
    chk("coinc_out_pre", 32'(dut.out_q), 32'd1);
    i_pc    = 32'hFFFF_FFF0;
    i_pcadd = 32'h0000_0008;
    i_setpc = 1'b1;
    push_batch(32'hFFFF_FFF8);
    @(negedge clk);
    chk("coinc_hs_rsp", {30'd0, o_req_val, i_rsp_val}, 32'd3);
    chk("coinc_in_val_forced", 32'(o_in_val), 32'd0);
    tick();
    i_setpc = 1'b0;
    @(negedge clk);
    chk("coinc_drop", 32'(dut.drop_q), 32'd1);
    chk("coinc_occ", 32'(dut.occ_q), 32'd0);
    chk("coinc_in_val_empty", 32'(o_in_val), 32'd0);
    chk("wrap_addr0", o_req_addr, 32'hFFFF_FFF8);
    tick();
    @(negedge clk);
    chk("wrap_addr1", o_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_addr2", o_req_addr, 32'h0000_0000);
    d0 = delivered;
    wait_deliv(d0 + 4, "wrap_delivery");

    // Asynchronous reset mid-stream.
    repeat (5) tick();
    @(negedge clk);
    chk("pre_reset_in_val", 32'(o_in_val), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_val", 32'(o_in_val), 32'd0);
    chk("mid_rst_req_val", 32'(o_req_val), 32'd0);
    chk("mid_rst_pc_r", o_pc_r, RST_PC);
    chk("mid_rst_req_addr", o_req_addr, RST_PC);
    chk("mid_rst_occ", 32'(dut.occ_q), 32'd0);
    chk("mid_rst_out", 32'(dut.out_q), 32'd0);
    chk("mid_rst_drop", 32'(dut.drop_q), 32'd0);
    push_batch(RST_PC);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rerst_req_val", 32'(o_req_val), 32'd1);
    chk("rerst_req_addr", o_req_addr, RST_PC);
    d0 = delivered;
    wait_deliv(d0 + 3, "rerst_delivery");

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
